tx_module: RTL and testbench

UART transmit engine; the transmit counterpart to the UART receiver. It accepts one character at a time over a valid/ready handshake and serialises it onto `uart_tx_o` as start bit, 5–8 data bits (LSB first), optional even parity, and 1–4 stop bits. Bit timing uses the shared 16x oversampling `baud_en_i` tick. The block sits between the UART register/FIFO front end and the external Tx pin.

---
 rtl/tx_module.sv | 263 ++++++++++++++++++++++++++
 tb/tb_tx_module.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_module.sv
// tx_module: UART transmit engine.
//
// Accepts one character over a valid/ready handshake and serialises it on
// uart_tx_o as start bit, 5-8 data bits (LSB first), optional even parity
// and 1-4 stop bits. Each bit lasts 16 ticks of the shared 16x baud enable.
//
// Optional feature macro: TX_HOLD_REG_EN
//   defined   : one-entry holding register; characters can be accepted while
//               a frame is in flight and frames run back to back.
//   undefined : no holding register; every frame is followed by Idle.
//
// Ports:
//   clk_i       top clock, rising edge
//   rst_ni      asynchronous active-low reset
//   baud_en_i   16x baud tick, one clk_i cycle wide
//   tx_en_i     transmit enable (gates new acceptances only)
//   tx_conf_i   {data[1:0], stop[1:0], parity_en}, latched with the character
//   tx_valid_i  character offered
//   tx_data_i   character; bits above the configured width are ignored
//   tx_ready_o  character accepted when tx_valid_i && tx_ready_o
//   tx_busy_o   frame in progress (start bit through last stop bit)
//   tx_done_o   one-cycle pulse per completed frame
//   uart_tx_o   registered serial line, idle high
//
// State table:
//   IDLE        | line high, waiting for a pending character and a baud tick
//   SEND_START  | driving the start bit (0)
//   SEND_DATA   | driving data bit bit_idx_q
//   SEND_PARITY | driving the even parity bit
//   SEND_STOP   | driving stop bit stop_idx_q (1)
module tx_module #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int STOP_CONF_W     = 2,
  parameter int DATA_CONF_W     = 2,
  parameter int SAMPLE_COUNT_W  = 4,
  parameter int TOTAL_CONF_W    = 5,
  parameter int DATA_COUNTER_W  = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       baud_en_i,
  input  logic                       tx_en_i,
  input  logic [TOTAL_CONF_W-1:0]    tx_conf_i,
  input  logic                       tx_valid_i,
  input  logic [MAX_UART_DATA_W-1:0] tx_data_i,
  output logic                       tx_ready_o,
  output logic                       tx_busy_o,
  output logic                       tx_done_o,
  output logic                       uart_tx_o
);

  localparam int MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    SEND_DATA,
    SEND_PARITY,
    SEND_STOP
  } state_t;

  state_t                      state_q, state_d;
  logic [SAMPLE_COUNT_W-1:0]   tick_q;
  logic [DATA_COUNTER_W-1:0]   bit_idx_q, bit_idx_d;
  logic [STOP_CONF_W-1:0]      stop_idx_q, stop_idx_d;
  logic [MAX_UART_DATA_W-1:0]  char_q;
  logic [DATA_CONF_W-1:0]      data_cfg_q;
  logic [STOP_CONF_W-1:0]      stop_cfg_q;
  logic                        par_en_q, par_bit_q;
  logic                        pending_q;
  logic                        line_q, line_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic                        accept, final_tick, last_data, last_stop;
  logic                        frame_end, start_frame, more;
  logic                        load_in, load_en;
  logic [MAX_UART_DATA_W-1:0]  load_data;
  logic [TOTAL_CONF_W-1:0]     load_conf;

  // Even parity over only the configured number of data bits.
  function automatic logic even_parity(input logic [MAX_UART_DATA_W-1:0] d,
                                       input logic [DATA_CONF_W-1:0] w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < MAX_UART_DATA_W; i++) begin
      if (i < MIN_DATA_BITS + int'(w)) p = p ^ d[i];
    end
    return p;
  endfunction

  assign accept      = tx_valid_i && tx_ready_o;
  assign final_tick  = baud_en_i && (tick_q == {SAMPLE_COUNT_W{1'b1}});
  assign last_data   = (bit_idx_q == (DATA_COUNTER_W'(data_cfg_q)
                                      + DATA_COUNTER_W'(MIN_DATA_BITS - 1)));
  assign last_stop   = (stop_idx_q == stop_cfg_q);
  assign frame_end   = (state_q == SEND_STOP) && final_tick && last_stop;
  assign start_frame = (state_q == IDLE) && baud_en_i && pending_q;

`ifdef TX_HOLD_REG_EN
  logic                       hold_valid_q;
  logic [MAX_UART_DATA_W-1:0] hold_data_q;
  logic [TOTAL_CONF_W-1:0]    hold_conf_q;
  logic                       shift_free, load_hold;

  // The shift register is free only in Idle with nothing waiting to start;
  // otherwise an accepted character parks in the holding register.
  assign shift_free = (state_q == IDLE) && !pending_q;
  assign tx_ready_o = rst_ni && tx_en_i && !hold_valid_q;
  assign load_in    = accept && shift_free;
  assign load_hold  = hold_valid_q && (shift_free || frame_end);
  assign more       = hold_valid_q;
  assign load_en    = load_in || load_hold;
  assign load_data  = load_hold ? hold_data_q : tx_data_i;
  assign load_conf  = load_hold ? hold_conf_q : tx_conf_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_conf_q  <= '0;
    end else if (accept && !shift_free) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= tx_data_i;
      hold_conf_q  <= tx_conf_i;
    end else if (load_hold) begin
      hold_valid_q <= 1'b0;
    end
  end
`else
  assign tx_ready_o = rst_ni && tx_en_i && (state_q == IDLE) && !pending_q;
  assign load_in    = accept;
  assign more       = 1'b0;
  assign load_en    = load_in;
  assign load_data  = tx_data_i;
  assign load_conf  = tx_conf_i;
`endif

  // Character and its configuration are captured together so a later
  // configuration change cannot affect the frame they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      char_q     <= '0;
      data_cfg_q <= '0;
      stop_cfg_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      if (load_en) begin
        char_q     <= load_data;
        data_cfg_q <= load_conf[TOTAL_CONF_W-1 -: DATA_CONF_W];
        stop_cfg_q <= load_conf[STOP_CONF_W:1];
        par_en_q   <= load_conf[0];
        par_bit_q  <= even_parity(load_data, load_conf[TOTAL_CONF_W-1 -: DATA_CONF_W]);
      end
      // A load at frame end goes straight to SEND_START, so pending only
      // tracks characters waiting in Idle for the next baud tick.
      if (start_frame) pending_q <= 1'b0;
      else if (load_en && (state_q == IDLE)) pending_q <= 1'b1;
    end
  end

  // Tick counter wraps 15 -> 0, so it is already zero at every bit entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_q <= '0;
    else if (state_q == IDLE) tick_q <= '0;
    else if (baud_en_i) tick_q <= tick_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      stop_idx_q <= '0;
      line_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      line_q     <= line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    line_d     = line_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (start_frame) begin
          state_d = SEND_START;
          line_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SEND_START: begin
        if (final_tick) begin
          state_d   = SEND_DATA;
          bit_idx_d = '0;
          line_d    = char_q[0];
        end
      end
      SEND_DATA: begin
        if (final_tick) begin
          if (last_data) begin
            stop_idx_d = '0;
            if (par_en_q) begin
              state_d = SEND_PARITY;
              line_d  = par_bit_q;
            end else begin
              state_d = SEND_STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            line_d    = char_q[bit_idx_d];
          end
        end
      end
      SEND_PARITY: begin
        if (final_tick) begin
          state_d    = SEND_STOP;
          stop_idx_d = '0;
          line_d     = 1'b1;
        end
      end
      SEND_STOP: begin
        if (frame_end) begin
          done_d = 1'b1;
          if (more) begin
            state_d = SEND_START;
            line_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            line_d  = 1'b1;
          end
        end else if (final_tick) begin
          stop_idx_d = stop_idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign uart_tx_o = line_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_tx_module.sv
module tb_tx_module;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_en;
  logic       tx_en;
  logic [4:0] tx_conf;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_tx;

  tx_module dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .baud_en_i  (baud_en),
    .tx_en_i    (tx_en),
    .tx_conf_i  (tx_conf),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_ready_o (tx_ready),
    .tx_busy_o  (tx_busy),
    .tx_done_o  (tx_done),
    .uart_tx_o  (uart_tx)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [13:0] bits;
    int          n;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic [4:0] conf;
    int         ticks;
  } vec_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int baud_div = 1;
  int bcnt = 0;
  int done_cnt = 0;
  int cur_len = 0;
  int last_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: start, data LSB first, even parity, stop bits.
  function automatic frame_t model_frame(input logic [7:0] d, input logic [4:0] c);
    frame_t f;
    int nd;
    logic p;
    nd = 5 + int'(c[4:3]);
    f.bits = '1;
    f.n = 0;
    p = 1'b0;
    f.bits[f.n] = 1'b0;
    f.n++;
    for (int i = 0; i < nd; i++) begin
      f.bits[f.n] = d[i];
      p = p ^ d[i];
      f.n++;
    end
    if (c[0]) begin
      f.bits[f.n] = p;
      f.n++;
    end
    f.n += 1 + int'(c[2:1]);
    return f;
  endfunction

  // Baud enable generator: changes just after the rising edge.
  initial begin
    baud_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bcnt = (bcnt + 1) % baud_div;
      baud_en = (baud_div == 1) || (bcnt == 0);
    end
  end

  // Busy-length and done-pulse bookkeeping.
  initial forever begin
    @(negedge clk);
    if (tx_done === 1'b1) done_cnt++;
    if (tx_busy === 1'b1) cur_len++;
    else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len = 0;
    end
  end

  // Line monitor: pops the expected frame at each start bit and requires
  // every bit to hold its value for exactly 16 baud ticks.
  bit     m_in_frame = 1'b0;
  bit     m_chk_done = 1'b0;
  bit     m_skip = 1'b0;
  bit     m_ok = 1'b1;
  logic   m_badv = 1'b0;
  int     m_bidx = 0;
  int     m_cnt = 0;
  frame_t m_cur;

  initial forever begin
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      m_in_frame = 1'b0;
      m_chk_done = 1'b0;
      m_skip = 1'b0;
    end else begin
      if (m_chk_done) begin
        check("done_pulse", tx_done, 1);
        m_chk_done = 1'b0;
      end
      if (m_skip && uart_tx === 1'b1) m_skip = 1'b0;
      if (!m_in_frame && !m_skip && uart_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_start: line low with no frame queued (t=%0t)", $time);
          m_skip = 1'b1;
        end else begin
          m_cur = exp_q.pop_front();
          m_in_frame = 1'b1;
          m_bidx = 0;
          m_cnt = 0;
          m_ok = 1'b1;
        end
      end
      if (m_in_frame) begin
        if (uart_tx !== m_cur.bits[m_bidx] && m_ok) begin
          m_ok = 1'b0;
          m_badv = uart_tx;
        end
        if (baud_en === 1'b1) begin
          m_cnt++;
          if (m_cnt == 16) begin
            check($sformatf("frame_bit%0d", m_bidx),
                  m_ok ? m_cur.bits[m_bidx] : m_badv, m_cur.bits[m_bidx]);
            m_cnt = 0;
            m_ok = 1'b1;
            m_bidx++;
            if (m_bidx == m_cur.n) begin
              m_in_frame = 1'b0;
              m_chk_done = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [4:0] c, input bit chk_lat);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    exp_q.push_back(model_frame(d, c));
    @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_conf  = c;
    while (!acc && n < 2000) begin
      @(negedge clk);
      if (tx_ready === 1'b1) acc = 1'b1;
      n++;
    end
    check("accept", acc, 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    tx_conf  = 5'($urandom);
    if (chk_lat) begin
      @(negedge clk);
      check("latency_idle", uart_tx, 1);
      @(negedge clk);
      check("latency_start", uart_tx, 0);
    end
  endtask

  task automatic wait_frame();
    int n;
    bit seen, fin;
    n = 0;
    seen = 1'b0;
    fin = 1'b0;
    while (!fin && n < 20000) begin
      @(negedge clk);
      n++;
      if (tx_busy === 1'b1) seen = 1'b1;
      else if (seen) fin = 1'b1;
    end
    check("frame_complete", fin, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vec[7];

  initial begin
    int d0;
    bit ok;
    int n;
    bit seen, fin;

    vec[0] = '{8'hA5, 5'b11000, 160};
    vec[1] = '{8'h1B, 5'b00011, 144};
    vec[2] = '{8'h0F, 5'b01101, 176};
    vec[3] = '{8'hE3, 5'b10111, 208};
    vec[4] = '{8'hFF, 5'b00000, 112};
    vec[5] = '{8'h6C, 5'b11111, 224};
    vec[6] = '{8'h00, 5'b11001, 176};

    rst_n    = 1'b0;
    tx_en    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_conf  = 5'b11000;
    repeat (3) @(negedge clk);
    check("rst_line", uart_tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", tx_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", tx_ready, 1);

    // Table-driven single frames, baud enable tied high.
    for (int i = 0; i < 7; i++) begin
      d0 = done_cnt;
      send(vec[i].data, vec[i].conf, 1'b1);
      wait_frame();
      check($sformatf("busy_len_v%0d", i), last_len, vec[i].ticks);
      check($sformatf("done_cnt_v%0d", i), done_cnt - d0, 1);
    end

`ifdef TX_HOLD_REG_EN
    // Back-to-back frames through the holding register.
    d0 = done_cnt;
    send(8'h55, 5'b11000, 1'b0);
    send(8'hAA, 5'b11000, 1'b0);
    wait_frame();
    check("b2b_busy_len", last_len, 320);
    check("b2b_done_cnt", done_cnt - d0, 2);
`else
    // Valid held high through a frame: ready stays low until busy falls.
    send(8'h55, 5'b11000, 1'b0);
    exp_q.push_back(model_frame(8'hAA, 5'b11000));
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    tx_conf  = 5'b11000;
    ok = 1'b1;
    n = 0;
    seen = 1'b0;
    fin = 1'b0;
    while (!fin && n < 1000) begin
      @(negedge clk);
      n++;
      if (tx_busy === 1'b1) seen = 1'b1;
      else if (seen) fin = 1'b1;
      if (!fin && tx_ready !== 1'b0) ok = 1'b0;
    end
    check("ready_low_while_busy", ok, 1);
    check("ready_after_frame", tx_ready, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    check("restart_idle", uart_tx, 1);
    @(negedge clk);
    check("restart_start", uart_tx, 0);
    wait_frame();
    check("restart_busy_len", last_len, 160);
`endif

    // Reset in the middle of data bit 3.
    send(8'hC3, 5'b11000, 1'b0);
    n = 0;
    while (tx_busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (71) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line", uart_tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_ready", tx_ready, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    d0 = done_cnt;
    send(8'h3C, 5'b11000, 1'b1);
    wait_frame();
    check("post_rst_busy_len", last_len, 160);
    check("post_rst_done_cnt", done_cnt - d0, 1);

    // Slow baud, enable dropped mid-frame.
    baud_div = 4;
    d0 = done_cnt;
    send(8'h96, 5'b11000, 1'b0);
    repeat (200) @(posedge clk);
    #1 tx_en = 1'b0;
    wait_frame();
    check("slow_busy_len", last_len, 640);
    check("slow_done_cnt", done_cnt - d0, 1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_ready !== 1'b0) ok = 1'b0;
    end
    check("ready_low_disabled", ok, 1);
    tx_en = 1'b1;
    baud_div = 1;
    repeat (4) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
